// File: rtl/ysyx_24100005_lsu_pkg.sv
// Shared types and constants for the ysyx_24100005 load/store unit.
package ysyx_24100005_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;

endpackage

// File: rtl/ysyx_24100005_lsu_align.sv
// Combinational lane logic: store shift/mask, request legality check, load extract/extend.
module ysyx_24100005_lsu_align
  import ysyx_24100005_lsu_pkg::*;
(
  input  logic        req_is_store,
  input  logic [2:0]  req_funct3,
  input  logic [1:0]  req_offset,
  input  logic [31:0] req_wdata,
  output logic [31:0] st_wdata,
  output logic [3:0]  st_wmask,
  output logic        req_err,
  input  logic [2:0]  ld_funct3,
  input  logic [1:0]  ld_offset,
  input  logic [31:0] ld_raw,
  output logic [31:0] ld_data
);

  logic        legal;
  logic        misaligned;
  logic [31:0] shifted;

  assign st_wdata = req_wdata << {req_offset, 3'b000};

  always_comb begin
    legal      = 1'b0;
    misaligned = 1'b0;
    st_wmask   = 4'b0000;
    unique case (req_funct3)
      F3_B:  legal = 1'b1;
      F3_H:  begin legal = 1'b1; misaligned = req_offset[0];        end
      F3_W:  begin legal = 1'b1; misaligned = (req_offset != 2'b00); end
      F3_BU: legal = !req_is_store;
      F3_HU: begin legal = !req_is_store; misaligned = req_offset[0]; end
      default: legal = 1'b0;
    endcase
    if (req_is_store) begin
      unique case (req_funct3)
        F3_B:    st_wmask = MASK_B << req_offset;
        F3_H:    st_wmask = MASK_H << req_offset;
        F3_W:    st_wmask = MASK_W;
        default: st_wmask = 4'b0000;
      endcase
    end
  end

  assign req_err = !legal || misaligned;

  // Loads read the whole word; the addressed byte/half is moved down to bit 0 before extension.
  assign shifted = ld_raw >> {ld_offset, 3'b000};

  always_comb begin
    ld_data = 32'd0;
    unique case (ld_funct3)
      F3_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    ld_data = shifted;
      F3_BU:   ld_data = {24'd0, shifted[7:0]};
      F3_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = 32'd0;
    endcase
  end

endmodule

// File: rtl/ysyx_24100005_lsu.sv
// Load/store unit: one outstanding request, valid/ready memory port, timeout, one-cycle response.
module ysyx_24100005_lsu
  import ysyx_24100005_lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid,
  output logic                  up_ready,
  input  logic                  up_is_store,
  input  logic [2:0]            up_funct3,
  input  logic [ADDR_WIDTH-1:0] up_addr,
  input  logic [31:0]           up_wdata,
  output logic                  resp_valid,
  output logic [31:0]           resp_rdata,
  output logic                  resp_err,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic [3:0]            mem_wmask,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata
);

  lsu_state_t  state, state_next;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_offset;
  logic [15:0] tcount;
  logic        timeout_hit;
  logic [31:0] st_wdata;
  logic [3:0]  st_wmask;
  logic        req_err;
  logic [31:0] ld_data;

  ysyx_24100005_lsu_align u_align (
    .req_is_store (up_is_store),
    .req_funct3   (up_funct3),
    .req_offset   (up_addr[1:0]),
    .req_wdata    (up_wdata),
    .st_wdata     (st_wdata),
    .st_wmask     (st_wmask),
    .req_err      (req_err),
    .ld_funct3    (cap_funct3),
    .ld_offset    (cap_offset),
    .ld_raw       (mem_rdata),
    .ld_data      (ld_data)
  );

  // True on the edge that would complete the TIMEOUT_CYCLES-th cycle spent in REQ+WAIT.
  assign timeout_hit   = ({1'b0, tcount} + 17'd1) >= 17'(TIMEOUT_CYCLES);
  assign up_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign resp_valid    = (state == RESP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (up_valid) state_next = req_err ? RESP : REQ;
      REQ: begin
        if (timeout_hit)        state_next = RESP;
        else if (mem_req_ready) state_next = WAIT;
      end
      WAIT: if (mem_rvalid || timeout_hit) state_next = RESP;
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Response registers only change on entry to RESP so they hold between pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_funct3 <= 3'd0;
      cap_offset <= 2'd0;
      tcount     <= 16'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= 32'd0;
      mem_wmask  <= 4'd0;
    end else begin
      unique case (state)
        IDLE: if (up_valid) begin
          cap_funct3 <= up_funct3;
          cap_offset <= up_addr[1:0];
          tcount     <= 16'd0;
          if (req_err) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b1;
          end else begin
            mem_we    <= up_is_store;
            mem_addr  <= {up_addr[ADDR_WIDTH-1:2], 2'b00};
            mem_wdata <= st_wdata;
            mem_wmask <= st_wmask;
          end
        end
        REQ: begin
          tcount <= tcount + 16'd1;
          if (timeout_hit) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b1;
          end
        end
        WAIT: begin
          tcount <= tcount + 16'd1;
          if (mem_rvalid) begin
            resp_rdata <= mem_we ? 32'd0 : ld_data;
            resp_err   <= 1'b0;
          end else if (timeout_hit) begin
            resp_rdata <= 32'd0;
            resp_err   <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_24100005_lsu.sv
// Self-checking bench for ysyx_24100005_lsu: directed plan items plus randomized requests vs a reference model.
module tb_ysyx_24100005_lsu;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        up_valid, up_ready, up_is_store;
  logic [2:0]  up_funct3;
  logic [31:0] up_addr, up_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic        mem_req_valid, mem_req_ready, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ysyx_24100005_lsu #(.ADDR_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .up_valid(up_valid), .up_ready(up_ready), .up_is_store(up_is_store),
    .up_funct3(up_funct3), .up_addr(up_addr), .up_wdata(up_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Behavioural model built from the RV32I width/sign rules with plain arithmetic.
  task automatic refModel(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd,
                          output logic err, output logic [31:0] exp_rdata,
                          output logic [31:0] exp_wdata, output logic [3:0] exp_mask);
    int off, size;
    logic legal;
    logic [31:0] v;
    off  = int'(addr % 4);
    size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    if (st) legal = (f3 <= 3'd2);
    else    legal = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    err = !legal || (off % size != 0);
    exp_wdata = wd << (8 * off);
    exp_mask  = st ? 4'(((1 << size) - 1) << off) : 4'd0;
    v = rd >> (8 * off);
    if (size == 1) begin
      v = v & 32'hFF;
      if (f3 < 4 && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (size == 2) begin
      v = v & 32'hFFFF;
      if (f3 < 4 && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end
    exp_rdata = st ? 32'd0 : v;
  endtask

  task automatic applyStimulus(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wd, input logic [31:0] rd,
                               input int stall, input string tag);
    logic e;
    logic [31:0] er, ew;
    logic [3:0] em;
    refModel(st, f3, addr, wd, rd, e, er, ew, em);
    checkOutput({tag, ".up_ready"}, 32'(up_ready), 32'd1);
    up_valid = 1'b1; up_is_store = st; up_funct3 = f3; up_addr = addr; up_wdata = wd;
    tick();
    up_valid = 1'b0; up_addr = $urandom; up_wdata = $urandom; up_funct3 = 3'($urandom);
    if (e) begin
      checkOutput({tag, ".err_req_valid"}, 32'(mem_req_valid), 32'd0);
      checkOutput({tag, ".err_resp_valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, ".err_flag"}, 32'(resp_err), 32'd1);
      checkOutput({tag, ".err_rdata"}, resp_rdata, 32'd0);
      tick();
      checkOutput({tag, ".err_done"}, {30'd0, resp_valid, up_ready}, 32'd1);
    end else begin
      for (int c = 0; c <= stall; c++) begin
        checkOutput({tag, ".req_valid"}, 32'(mem_req_valid), 32'd1);
        checkOutput({tag, ".addr"}, mem_addr, addr & 32'hFFFF_FFFC);
        checkOutput({tag, ".we"}, 32'(mem_we), 32'(st));
        checkOutput({tag, ".mask"}, 32'(mem_wmask), 32'(em));
        if (st) checkOutput({tag, ".wdata"}, mem_wdata, ew);
        if (c < stall) begin
          mem_rvalid = 1'b1; mem_rdata = ~rd;
          tick();
          mem_rvalid = 1'b0;
        end
      end
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      checkOutput({tag, ".wait"}, {30'd0, mem_req_valid, resp_valid}, 32'd0);
      mem_rvalid = 1'b1; mem_rdata = rd;
      tick();
      mem_rvalid = 1'b0; mem_rdata = $urandom;
      checkOutput({tag, ".resp_valid"}, 32'(resp_valid), 32'd1);
      checkOutput({tag, ".resp_err"}, 32'(resp_err), 32'd0);
      checkOutput({tag, ".resp_rdata"}, resp_rdata, er);
      tick();
      checkOutput({tag, ".done"}, {30'd0, resp_valid, up_ready}, 32'd1);
    end
  endtask

  initial begin
    int cyc;
    rst = 1'b1; up_valid = 1'b0; up_is_store = 1'b0; up_funct3 = 3'd0; up_addr = 32'd0;
    up_wdata = 32'd0; mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'd0;
    tick(); tick();
    checkOutput("reset.ctrl", {28'd0, up_ready, resp_valid, mem_req_valid, resp_err}, 32'h8);
    checkOutput("reset.mem", {mem_addr[27:0], mem_wmask} | mem_wdata | resp_rdata | 32'(mem_we), 32'd0);
    rst = 1'b0;
    tick();

    applyStimulus(1'b1, 3'b010, 32'h8000_0010, 32'hDEAD_BEEF, 32'h0, 0, "sw");
    applyStimulus(1'b1, 3'b000, 32'h8000_0013, 32'h0000_00A5, 32'h0, 0, "sb_lane3");
    applyStimulus(1'b0, 3'b000, 32'h8000_0021, 32'h0, 32'h80F0_7F81, 0, "lb_off1");
    applyStimulus(1'b0, 3'b000, 32'h8000_0023, 32'h0, 32'h80F0_7F81, 0, "lb_off3");
    applyStimulus(1'b0, 3'b101, 32'h8000_0022, 32'h0, 32'h80F0_7F81, 0, "lhu_off2");
    applyStimulus(1'b0, 3'b001, 32'h8000_0022, 32'h0, 32'h80F0_7F81, 0, "lh_off2");
    applyStimulus(1'b0, 3'b010, 32'h8000_0002, 32'h0, 32'h1234_5678, 0, "lw_misalign");
    applyStimulus(1'b0, 3'b001, 32'h8000_0001, 32'h0, 32'h1234_5678, 0, "lh_misalign");
    applyStimulus(1'b0, 3'b011, 32'h8000_0000, 32'h0, 32'h1234_5678, 0, "illegal_f3");
    applyStimulus(1'b1, 3'b001, 32'h8000_0042, 32'h0000_C3D4, 32'h0, 3, "sh_backpressure");

    // Timeout: ready immediately, no rvalid ever; response forced after TO cycles in REQ+WAIT.
    up_valid = 1'b1; up_is_store = 1'b0; up_funct3 = 3'b010; up_addr = 32'h8000_0100;
    tick();
    up_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 40) begin
      tick();
      cyc++;
    end
    checkOutput("timeout.latency", 32'(cyc), 32'(TO));
    checkOutput("timeout.err", {30'd0, resp_valid, resp_err}, 32'd3);
    checkOutput("timeout.rdata", resp_rdata, 32'd0);
    tick();
    mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("late_rvalid.no_resp", {30'd0, resp_valid, up_ready}, 32'd1);
    tick();
    checkOutput("late_rvalid.still_idle", {30'd0, resp_valid, up_ready}, 32'd1);

    // Reset between edges while waiting for read data.
    up_valid = 1'b1; up_is_store = 1'b0; up_funct3 = 3'b010; up_addr = 32'h8000_0200;
    tick();
    up_valid = 1'b0; mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_async.ctrl", {29'd0, up_ready, resp_valid, mem_req_valid}, 32'h4);
    checkOutput("rst_async.mem", mem_addr | mem_wdata | 32'(mem_wmask), 32'd0);
    tick();
    mem_rvalid = 1'b1;
    rst = 1'b0;
    tick();
    mem_rvalid = 1'b0;
    checkOutput("rst_release.idle", {30'd0, resp_valid, up_ready}, 32'd1);
    applyStimulus(1'b0, 3'b010, 32'h8000_0300, 32'h0, 32'hCAFE_F00D, 0, "lw_after_rst");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_24100005_lsu.md
Name: ysyx_24100005_lsu

Overview:
Load/store unit that sits directly downstream of the single-cycle datapath's address adder. It replaces the ad-hoc combinational `npcmem_read` call with a registered, handshaked memory access.
- Accepts one load/store request at a time.
- Aligns store data and generates byte masks.
- Drives a valid/ready memory port.
- Extracts and sign/zero-extends load data.
- Returns a one-cycle response to the write-back stage.

Parameters:
ADDR_WIDTH, 32, byte address width of upstream and memory ports.
TIMEOUT_CYCLES, 255, cycles spent in REQ+WAIT before a bus-error response is forced; valid range 1..65535.

Ports:
clk  in  1  clock; all state updates on posedge.
rst  in  1  reset, asynchronous, active-high.
up_valid  in  1  request from execute stage.
up_ready  out  1  LSU can accept a request; high exactly when state is IDLE.
up_is_store  in  1  1 = store, 0 = load.
up_funct3  in  3  RV32I width/sign code.
up_addr  in  ADDR_WIDTH  effective byte address (adder output).
up_wdata  in  32  rs2 data for stores.
resp_valid  out  1  one-cycle completion pulse.
resp_rdata  out  32  extended load data; 0 for stores and errors.
resp_err  out  1  misaligned, illegal funct3, or timeout.
mem_req_valid  out  1  memory request.
mem_req_ready  in  1  memory accepts the request.
mem_we  out  1  write enable.
mem_addr  out  ADDR_WIDTH  word-aligned address; low 2 bits forced to 0.
mem_wdata  out  32  lane-shifted store data.
mem_wmask  out  4  byte-lane mask; 0 for loads.
mem_rvalid  in  1  read data valid / write acknowledge.
mem_rdata  in  32  raw word read data.

Behaviour:
- Reset values: resp_valid=0, resp_rdata=0, resp_err=0, mem_req_valid=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0. State=IDLE, so up_ready=1. Timeout counter=0.
- Reset asserted mid-operation: immediate (asynchronous) return to IDLE and all outputs to reset values. A later mem_rvalid from the aborted transaction is ignored.
- States: IDLE, REQ, WAIT, RESP.
- IDLE: on up_valid (up_ready=1), capture the request; offset = up_addr[1:0].
  - Legal load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu.
  - Legal store funct3: 000 sb, 001 sh, 010 sw.
  - Any other code is illegal -> RESP with err=1, no memory access.
  - Misaligned (lh/lhu/sh with offset[0]=1; lw/sw with offset!=0) -> RESP with err=1, no memory access.
  - Otherwise -> REQ. Load mem outputs from the capture.
- REQ: mem_req_valid=1; mem_addr, mem_we, mem_wdata, mem_wmask held stable until mem_req_ready=1, then -> WAIT.
- WAIT: on mem_rvalid=1, latch the response and -> RESP. mem_rvalid during REQ is ignored.
- Timeout: the counter increments every cycle in REQ or WAIT and clears on accept. If it reaches TIMEOUT_CYCLES before completion -> RESP with err=1, and mem_req_valid drops.
- RESP: resp_valid=1 for exactly one cycle, then -> IDLE. No backpressure; the consumer must take the pulse. resp_rdata/resp_err hold their value until the next RESP.
- Store lanes: mem_wdata = up_wdata << (8*offset).
  - mem_wmask: sb = 4'b0001<<offset; sh = 4'b0011<<offset; sw = 4'b1111.
- Load extract: shifted = mem_rdata >> (8*offset).
  - lb/lh: sign-extend bits [7:0]/[15:0].
  - lbu/lhu: zero-extend.
  - lw: pass through.
- Latency (accept at edge N): mem_req_valid high from N+1. With mem_req_ready at N+1 and mem_rvalid at N+2, resp_valid is asserted at N+3. Error path: resp_valid at N+1.
- Throughput: at most one request outstanding; up_ready=0 during REQ/WAIT/RESP.

Decomposition:
- Package ysyx_24100005_lsu_pkg:
  - state enum {IDLE, REQ, WAIT, RESP};
  - funct3 constants F3_B/H/W/BU/HU;
  - localparam MASK_B=4'b0001, MASK_H=4'b0011, MASK_W=4'b1111.
- One combinational sub-module, ysyx_24100005_lsu_align:
  - store shift/mask generation;
  - load extract/extend;
  - misalign/illegal detection.
- The FSM, capture registers and timeout counter stay in ysyx_24100005_lsu.

Test Plan:
- Store word: sw addr=0x8000_0010, wdata=0xDEAD_BEEF, mem_req_ready=1 immediately, rvalid next cycle -> mem_addr=0x8000_0010, mask=1111, wdata=0xDEAD_BEEF; resp_valid at N+3, err=0, rdata=0.
- Byte store lane: sb addr=0x8000_0013, wdata=0x0000_00A5 -> mem_addr=0x8000_0010, mask=1000, mem_wdata=0xA500_0000.
- Load extension: mem_rdata=0x80F0_7F81.
  - lb @off1 -> 0x0000_007F.
  - lb @off3 -> 0xFFFF_FF80.
  - lhu @off2 -> 0x0000_80F0.
  - lh @off2 -> 0xFFFF_80F0.
- Misaligned/illegal: lw addr=0x8000_0002; lh addr=0x8000_0001; funct3=011 load -> mem_req_valid never asserted; resp_valid at N+1 with err=1.
- Backpressure and timeout:
  - mem_req_ready low 3 cycles -> mem_addr/wdata/mask stable throughout; response after ready+rvalid.
  - TIMEOUT_CYCLES=8 and no rvalid -> err=1 response; a late mem_rvalid in IDLE causes no resp_valid.
- Reset mid-WAIT: assert rst between edges -> mem_req_valid and resp_valid drop immediately; after release, up_ready=1 and a new lw completes normally.
